ncpu32k_stream_fifo: RTL and testbench

Synchronous valid/ready FIFO that decouples a producer pipeline stage from a consumer stage. It is used between fetch and decode, and between LSU response and writeback. It extends the plain load-enabled register with the consumer side of the handshake: the write port accepts on `I_VALID && I_READY`, and the read port drains on `O_VALID && O_READY`. Depth is a power of two, storage is a flop array, and occupancy is exported for flow-control heuristics.

---
 rtl/ncpu32k_stream_fifo_pkg.sv | 26 ++
 rtl/ncpu32k_fifo_mem.sv | 36 +++
 rtl/ncpu32k_stream_fifo.sv | 106 ++++++++++
 tb/tb_ncpu32k_stream_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncpu32k_stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ncpu32k_stream_fifo_pkg
//  Desc     : Shared sizing helpers for the valid/ready stream FIFO. Pointer
//             width and entry count are derived from DEPTH_LOG2 here so the
//             top level and the storage array always agree.
//  Revision : 1.0 - initial release
// ============================================================================
package ncpu32k_stream_fifo_pkg;

    // Smallest and largest supported DEPTH_LOG2 values
    localparam int unsigned FIFO_DEPTH_LOG2_MIN = 1;
    localparam int unsigned FIFO_DEPTH_LOG2_MAX = 6;

    // Number of storage entries for a given DEPTH_LOG2
    function automatic int unsigned fifo_depth(input int unsigned depth_log2);
        return 32'd1 << depth_log2;
    endfunction

    // Pointer width: address bits plus one wrap bit
    function automatic int unsigned fifo_ptr_width(input int unsigned depth_log2);
        return depth_log2 + 32'd1;
    endfunction

endpackage : ncpu32k_stream_fifo_pkg
`default_nettype wire

// File: rtl/ncpu32k_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ncpu32k_fifo_mem
//  Desc     : 2^AW x DW flop array. One synchronous write port, one
//             asynchronous read port. Contents are never reset.
//  Revision : 1.0 - initial release
// ============================================================================
module ncpu32k_fifo_mem
    import ncpu32k_stream_fifo_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          WE_i,
    input  logic [AW-1:0] WADDR_i,
    input  logic [DW-1:0] WDATA_i,
    input  logic [AW-1:0] RADDR_i,
    output logic [DW-1:0] RDATA_o
);

    localparam int unsigned DEPTH = fifo_depth(AW);

    logic [DW-1:0] mem_q [0:DEPTH-1];

    // Write port: store data at the write address when enabled
    always_ff @(posedge CLK) begin
        if (WE_i) begin
            mem_q[WADDR_i] <= WDATA_i;
        end
    end

    assign RDATA_o = mem_q[RADDR_i];

endmodule : ncpu32k_fifo_mem
`default_nettype wire

// File: rtl/ncpu32k_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ncpu32k_stream_fifo
//  Desc     : Synchronous valid/ready FIFO with power-of-two depth, flop
//             storage, synchronous flush and exported occupancy.
//             Optional macro NCPU_FIFO_BYPASS_EN adds a zero-latency path
//             from I_* to O_* while the FIFO is empty.
//  Revision : 1.0 - initial release
// ============================================================================
module ncpu32k_stream_fifo
    import ncpu32k_stream_fifo_pkg::*;
#(
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  FLUSH,
    input  logic                  I_VALID,
    output logic                  I_READY,
    input  logic [DW-1:0]         I_DATA,
    output logic                  O_VALID,
    input  logic                  O_READY,
    output logic [DW-1:0]         O_DATA,
    output logic [DEPTH_LOG2:0]   COUNT
);

    localparam int PW = int'(fifo_ptr_width(DEPTH_LOG2));

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    // Status decoded purely from registered pointers
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                   (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

    // Ready ignores O_READY so no read-to-write combinational path exists
    assign I_READY = !full;
    assign push    = I_VALID && !full;
    assign pop     = !empty && O_READY;

`ifdef NCPU_FIFO_BYPASS_EN
    logic bypass_open;

    // Empty and not flushing: incoming item is presented directly
    assign bypass_open = empty && !FLUSH;
    assign O_VALID     = empty ? (bypass_open && I_VALID) : 1'b1;
    assign O_DATA      = !empty ? mem_rdata :
                         ((bypass_open && I_VALID) ? I_DATA : {DW{1'b0}});
    // A bypassed item taken in the same cycle is never written
    assign mem_we      = push && !FLUSH && !(bypass_open && O_READY);
`else
    assign O_VALID = !empty;
    assign O_DATA  = empty ? {DW{1'b0}} : mem_rdata;
    assign mem_we  = push && !FLUSH;
`endif

    // Next-state pointers; wrap happens naturally through the MSB
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (mem_we) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    // Pointer registers: async reset, flush overrides any push/pop
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (FLUSH) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign COUNT = wptr_q - rptr_q;

    ncpu32k_fifo_mem #(
        .DW (DW),
        .AW (DEPTH_LOG2)
    ) u_mem (
        .CLK     (CLK),
        .WE_i    (mem_we),
        .WADDR_i (wptr_q[PW-2:0]),
        .WDATA_i (I_DATA),
        .RADDR_i (rptr_q[PW-2:0]),
        .RDATA_o (mem_rdata)
    );

endmodule : ncpu32k_stream_fifo
`default_nettype wire

// File: tb/tb_ncpu32k_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ncpu32k_stream_fifo
//  Desc     : Directed self-checking bench for ncpu32k_stream_fifo
//             (DW=32, depth 4). Follows NCPU_FIFO_BYPASS_EN if defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ncpu32k_stream_fifo;

`ifdef NCPU_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        RST_n;
    logic        FLUSH;
    logic        I_VALID;
    logic        I_READY;
    logic [31:0] I_DATA;
    logic        O_VALID;
    logic        O_READY;
    logic [31:0] O_DATA;
    logic [2:0]  COUNT;

    int n_chk;
    int n_fail;

    ncpu32k_stream_fifo #(
        .DW         (32),
        .DEPTH_LOG2 (2)
    ) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .FLUSH   (FLUSH),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .I_DATA  (I_DATA),
        .O_VALID (O_VALID),
        .O_READY (O_READY),
        .O_DATA  (O_DATA),
        .COUNT   (COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_data;
        logic        exp_valid;
        logic        m_push;
        logic        m_pop;
        int          sent;
        int          recv;
        int          cyc;

        n_chk   = 0;
        n_fail  = 0;
        RST_n   = 1'b0;
        FLUSH   = 1'b0;
        I_VALID = 1'b0;
        I_DATA  = '0;
        O_READY = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        chk("rst_iready", 32'(I_READY), 32'd1);
        chk("rst_ovalid", 32'(O_VALID), 32'd0);
        chk("rst_count",  32'(COUNT),   32'd0);
        chk("rst_odata",  O_DATA,       32'd0);
        RST_n = 1'b1;
        step();
        chk("post_rst_iready", 32'(I_READY), 32'd1);
        chk("post_rst_count",  32'(COUNT),   32'd0);

        // ---------------- fill ----------------
        O_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            I_VALID = 1'b1;
            I_DATA  = 32'hA0 + 32'(i);
            #1;
            chk("fill_iready", 32'(I_READY), 32'd1);
            step();
            chk("fill_count", 32'(COUNT), 32'(i + 1));
        end
        chk("full_iready", 32'(I_READY), 32'd0);
        chk("full_ovalid", 32'(O_VALID), 32'd1);
        chk("full_head",   O_DATA,       32'hA0);
        I_DATA = 32'hA4;
        step();
        chk("fifth_push_count", 32'(COUNT), 32'd4);
        chk("fifth_push_head",  O_DATA,     32'hA0);
        I_VALID = 1'b0;

        // ---------------- drain ----------------
        O_READY = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_ovalid", 32'(O_VALID), 32'd1);
            chk("drain_data",   O_DATA,       32'hA0 + 32'(i));
            step();
        end
        chk("drained_ovalid", 32'(O_VALID), 32'd0);
        chk("drained_count",  32'(COUNT),   32'd0);
        chk("drained_odata",  O_DATA,       32'd0);

        // ---------------- full with O_READY=1 ----------------
        O_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            I_VALID = 1'b1;
            I_DATA  = 32'hB0 + 32'(i);
            step();
        end
        chk("refill_count", 32'(COUNT), 32'd4);
        I_DATA  = 32'hB4;
        O_READY = 1'b1;
        #1;
        chk("full_pop_iready", 32'(I_READY), 32'd0);
        step();
        chk("full_pop_count", 32'(COUNT), 32'd3);
        I_VALID = 1'b0;
        #1;
        for (int i = 1; i < 4; i++) begin
            chk("full_pop_data", O_DATA, 32'hB0 + 32'(i));
            step();
        end
        chk("full_pop_empty", 32'(O_VALID), 32'd0);

        // ---------------- streaming with random stalls ----------------
        sent = 0;
        recv = 0;
        cyc  = 0;
        q.delete();
        while (recv < 20 && cyc < 300) begin
            I_VALID = (sent < 20);
            I_DATA  = 32'hC0 + 32'(sent);
            O_READY = 1'($urandom_range(0, 1));
            #1;
            exp_valid = (q.size() > 0) || (BYP && I_VALID);
            exp_data  = (q.size() > 0) ? q[0] : (exp_valid ? I_DATA : 32'd0);
            chk("stream_count",  32'(COUNT),   32'(q.size()));
            chk("stream_iready", 32'(I_READY), 32'(q.size() < 4));
            chk("stream_ovalid", 32'(O_VALID), 32'(exp_valid));
            chk("stream_odata",  O_DATA,       exp_data);
            m_push = I_VALID && (q.size() < 4);
            m_pop  = exp_valid && O_READY;
            if (m_pop) begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                end else begin
                    m_push = 1'b0;
                end
                recv++;
            end
            if (m_push) begin
                q.push_back(I_DATA);
            end
            if (I_VALID && (q.size() <= 4) && (m_push || (m_pop && BYP && exp_data == I_DATA && !m_push))) begin
                sent++;
            end
            step();
            cyc++;
        end
        chk("stream_done", 32'(recv), 32'd20);
        I_VALID = 1'b0;
        O_READY = 1'b1;
        step(); step(); step(); step(); step();
        chk("stream_final_count", 32'(COUNT), 32'd0);

        // ---------------- flush ----------------
        O_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            I_VALID = 1'b1;
            I_DATA  = 32'hD0 + 32'(i);
            step();
        end
        chk("preflush_count", 32'(COUNT), 32'd3);
        FLUSH   = 1'b1;
        I_VALID = 1'b1;
        I_DATA  = 32'hDF;
        O_READY = 1'b1;
        step();
        FLUSH   = 1'b0;
        I_VALID = 1'b0;
        O_READY = 1'b0;
        #1;
        chk("flush_count",  32'(COUNT),   32'd0);
        chk("flush_ovalid", 32'(O_VALID), 32'd0);
        chk("flush_odata",  O_DATA,       32'd0);
        I_VALID = 1'b1;
        I_DATA  = 32'hE0;
        step();
        chk("postflush_count", 32'(COUNT), 32'd1);
        chk("postflush_head",  O_DATA,     32'hE0);
        I_DATA = 32'hE1;
        step();
        I_VALID = 1'b0;
        #1;
        chk("prereset_count", 32'(COUNT), 32'd2);

        // ---------------- async reset between edges ----------------
        #1;
        RST_n = 1'b0;
        #1;
        chk("async_ovalid", 32'(O_VALID), 32'd0);
        chk("async_count",  32'(COUNT),   32'd0);
        RST_n = 1'b1;
        step();
        chk("async_post_count",  32'(COUNT),   32'd0);
        chk("async_post_iready", 32'(I_READY), 32'd1);

        // ---------------- bypass / latency ----------------
        I_DATA  = 32'h55;
        I_VALID = 1'b1;
        O_READY = 1'b1;
        #1;
        if (BYP) begin
            chk("byp_ovalid", 32'(O_VALID), 32'd1);
            chk("byp_odata",  O_DATA,       32'h55);
            chk("byp_count",  32'(COUNT),   32'd0);
            step();
            I_VALID = 1'b0;
            #1;
            chk("byp_next_count",  32'(COUNT),   32'd0);
            chk("byp_next_ovalid", 32'(O_VALID), 32'd0);
        end else begin
            chk("lat_ovalid", 32'(O_VALID), 32'd0);
            step();
            I_VALID = 1'b0;
            O_READY = 1'b0;
            #1;
            chk("lat_next_ovalid", 32'(O_VALID), 32'd1);
            chk("lat_next_odata",  O_DATA,       32'h55);
            chk("lat_next_count",  32'(COUNT),   32'd1);
            O_READY = 1'b1;
            step();
            chk("lat_drain_ovalid", 32'(O_VALID), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ncpu32k_stream_fifo
`default_nettype wire
